// File: rtl/me_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module  : me_scan_controller_if
// Brief   : Request/result and RAM/SPR control bundle of the ME scan controller.
// Rev     : 1.0  initial release
// ============================================================================
interface me_scan_controller_if #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int SAD_W      = 16
);
    localparam int NPOS = SEARCH_DIM - MACRO_DIM + 1;
    localparam int AW   = $clog2(SEARCH_DIM);
    localparam int PW   = ($clog2(NPOS) < 1) ? 1 : $clog2(NPOS);

    logic             start;
    logic             readyi;
    logic             early_en;
    logic [SAD_W-1:0] early_thr;
    logic [SAD_W-1:0] sad_in;
    logic             reset_sum;
    logic             en_cpr;
    logic             en_spr;
    logic             en_ram;
    logic [AW-1:0]    addr;
    logic [1:0]       sel;
    logic             comp_en;
    logic [PW-1:0]    cand_x;
    logic [PW-1:0]    cand_y;
    logic             valido;
    logic             readyo;
    logic [PW-1:0]    mv_x;
    logic [PW-1:0]    mv_y;
    logic [SAD_W-1:0] min_sad;

    // Requester side: issues searches, supplies SADs, consumes results.
    modport master (
        output start, early_en, early_thr, sad_in, readyo,
        input  readyi, reset_sum, en_cpr, en_spr, en_ram, addr, sel,
               comp_en, cand_x, cand_y, valido, mv_x, mv_y, min_sad
    );

    modport slave (
        input  start, early_en, early_thr, sad_in, readyo,
        output readyi, reset_sum, en_cpr, en_spr, en_ram, addr, sel,
               comp_en, cand_x, cand_y, valido, mv_x, mv_y, min_sad
    );
endinterface
`default_nettype wire

// File: rtl/me_scan_controller.sv
`default_nettype none
// ============================================================================
// Module  : me_scan_controller
// Brief   : Full-search motion-estimation sequencer with serpentine scan,
//           best-SAD tracking and optional early termination.
// Rev     : 1.0  initial release
// ============================================================================
module me_scan_controller #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int SAD_W      = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    me_scan_controller_if.slave  bus
);
    localparam int NPOS = SEARCH_DIM - MACRO_DIM + 1;
    localparam int AW   = $clog2(SEARCH_DIM);
    localparam int PW   = ($clog2(NPOS) < 1) ? 1 : $clog2(NPOS);

    localparam logic [PW-1:0] C_LAST_POS  = PW'(NPOS - 1);
    localparam logic [AW-1:0] C_LAST_LOAD = AW'(MACRO_DIM - 1);
    localparam logic [AW-1:0] C_MACRO     = AW'(MACRO_DIM);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_CPR = 3'd1,
        S_LOAD_SPR = 3'd2,
        S_SCAN     = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    x_q, x_d;
    logic [PW-1:0]    y_q, y_d;
    logic [PW-1:0]    mvx_q, mvx_d;
    logic [PW-1:0]    mvy_q, mvy_d;
    logic [SAD_W-1:0] best_q, best_d;
    logic [SAD_W-1:0] thr_q, thr_d;
    logic             early_q, early_d;

    logic w_even;
    logic w_last_row;
    logic w_last_col;
    logic w_better;
    logic w_early_hit;

    // Even columns walk down (y ascending), odd columns walk back up.
    assign w_even      = ~x_q[0];
    assign w_last_row  = w_even ? (y_q == C_LAST_POS) : (y_q == '0);
    assign w_last_col  = (x_q == C_LAST_POS);
    assign w_better    = (bus.sad_in < best_q);
    assign w_early_hit = early_q && (bus.sad_in <= thr_q);

    assign bus.mv_x    = mvx_q;
    assign bus.mv_y    = mvy_q;
    assign bus.min_sad = best_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            mvx_q   <= '0;
            mvy_q   <= '0;
            best_q  <= '1;
            thr_q   <= '0;
            early_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mvx_q   <= mvx_d;
            mvy_q   <= mvy_d;
            best_q  <= best_d;
            thr_q   <= thr_d;
            early_q <= early_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        x_d           = x_q;
        y_d           = y_q;
        mvx_d         = mvx_q;
        mvy_d         = mvy_q;
        best_d        = best_q;
        thr_d         = thr_q;
        early_d       = early_q;
        bus.readyi    = 1'b0;
        bus.reset_sum = 1'b0;
        bus.en_cpr    = 1'b0;
        bus.en_spr    = 1'b0;
        bus.en_ram    = 1'b0;
        bus.addr      = '0;
        bus.sel       = 2'd0;
        bus.comp_en   = 1'b0;
        bus.cand_x    = '0;
        bus.cand_y    = '0;
        bus.valido    = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.readyi    = 1'b1;
                bus.reset_sum = 1'b1;
                if (bus.start) begin
                    state_d = S_LOAD_CPR;
                    early_d = bus.early_en;
                    thr_d   = bus.early_thr;
                    best_d  = '1;
                    mvx_d   = '0;
                    mvy_d   = '0;
                    cnt_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            S_LOAD_CPR: begin
                bus.en_cpr = 1'b1;
                bus.en_ram = 1'b1;
                bus.addr   = cnt_q;
                if (cnt_q == C_LAST_LOAD) begin
                    cnt_d   = '0;
                    state_d = S_LOAD_SPR;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_LOAD_SPR: begin
                bus.en_spr = 1'b1;
                bus.sel    = 2'd1;
                bus.en_ram = 1'b1;
                bus.addr   = cnt_q;
                if (cnt_q == C_LAST_LOAD) begin
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_SCAN: begin
                bus.comp_en = 1'b1;
                bus.en_spr  = 1'b1;
                bus.cand_x  = x_q;
                bus.cand_y  = y_q;
                // An early hit always wins, even against an equal best.
                if (w_better || w_early_hit) begin
                    best_d = bus.sad_in;
                    mvx_d  = x_q;
                    mvy_d  = y_q;
                end
                if (!w_last_row) begin
                    // Fetch the row that enters the window on this shift.
                    bus.en_ram = 1'b1;
                    if (w_even) begin
                        bus.sel  = 2'd1;
                        bus.addr = AW'(y_q) + C_MACRO;
                        y_d      = y_q + PW'(1);
                    end else begin
                        bus.sel  = 2'd0;
                        bus.addr = AW'(y_q) - AW'(1);
                        y_d      = y_q - PW'(1);
                    end
                end else if (!w_last_col) begin
                    bus.sel = 2'd2;
                    x_d     = x_q + PW'(1);
                end else begin
                    bus.en_spr = 1'b0;
                end
                if (w_early_hit || (w_last_row && w_last_col)) begin
                    state_d = S_DONE;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            S_DONE: begin
                bus.valido = 1'b1;
                if (bus.readyo) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_me_scan_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_me_scan_controller
// Brief   : Randomized self-checking bench for me_scan_controller (4/8/16).
// Rev     : 1.0  initial release
// ============================================================================
module tb_me_scan_controller;
    localparam int M  = 4;
    localparam int S  = 8;
    localparam int W  = 16;
    localparam int NP = S - M + 1;
    localparam int AW = 3;
    localparam int PW = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   tab [0:NP-1][0:NP-1];
    int   exp_mvx;
    int   exp_mvy;
    int   exp_sad;

    me_scan_controller_if #(.MACRO_DIM(M), .SEARCH_DIM(S), .SAD_W(W)) bus ();

    me_scan_controller #(.MACRO_DIM(M), .SEARCH_DIM(S), .SAD_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serpentine position of the k-th candidate.
    function automatic void pos_of(input int k, output int x, output int y);
        x = k / NP;
        y = (x % 2 == 0) ? (k % NP) : (NP - 1 - (k % NP));
    endfunction

    task automatic fill_const(input int v);
        for (int x = 0; x < NP; x++)
            for (int y = 0; y < NP; y++)
                tab[x][y] = v;
    endtask

    task automatic fill_random(input int lo, input int hi);
        for (int x = 0; x < NP; x++)
            for (int y = 0; y < NP; y++)
                tab[x][y] = int'($urandom_range(hi, lo));
    endtask

    // Runs one search from IDLE, checking every cycle against the reference
    // scan, then the result; optionally consumes the result afterwards.
    task automatic run_search(input bit een, input int thr, input bit release_it);
        int best, idx, exp_end, x, y, r, s;
        bit lr, lc;
        logic [3:0]    e_en;
        logic [AW-1:0] e_addr;
        logic [1:0]    e_sel;
        int ex, ey;
        best = 32'hFFFF; exp_mvx = 0; exp_mvy = 0; idx = NP*NP - 1;
        for (int k = 0; k < NP*NP; k++) begin
            pos_of(k, x, y);
            s = tab[x][y];
            if (een && s <= thr) begin
                best = s; exp_mvx = x; exp_mvy = y; idx = k;
                break;
            end
            if (s < best) begin
                best = s; exp_mvx = x; exp_mvy = y;
            end
        end
        exp_sad = best;
        exp_end = 2*M + idx + 1;

        checks++;
        if (bus.readyi !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: readyi=%b required 1", bus.readyi);
        end
        bus.early_en  = een;
        bus.early_thr = W'(thr);
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.early_en  = ~een;
        bus.early_thr = een ? 16'd0 : 16'hFFFF;

        for (int c = 1; c <= exp_end; c++) begin
            e_addr = '0; e_sel = 2'd0; ex = 0; ey = 0;
            bus.sad_in = W'($urandom);
            if (c <= M) begin
                e_en = 4'b1010; e_addr = AW'(c - 1);
            end else if (c <= 2*M) begin
                e_en = 4'b0110; e_addr = AW'(c - M - 1); e_sel = 2'd1;
            end else begin
                pos_of(c - 2*M - 1, x, y);
                r  = (c - 2*M - 1) % NP;
                lr = (r == NP - 1);
                lc = (x == NP - 1);
                ex = x; ey = y;
                bus.sad_in = W'(tab[x][y]);
                if (!lr) begin
                    e_en   = 4'b0111;
                    e_sel  = (x % 2 == 0) ? 2'd1 : 2'd0;
                    e_addr = (x % 2 == 0) ? AW'(y + M) : AW'(y - 1);
                end else if (!lc) begin
                    e_en = 4'b0101; e_sel = 2'd2;
                end else begin
                    e_en = 4'b0001;
                end
            end
            checks++;
            if (bus.valido !== 1'b0 || bus.readyi !== 1'b0) begin
                errors++;
                $display("FAIL busy_flags c=%0d: valido=%b readyi=%b required 0 0", c, bus.valido, bus.readyi);
            end
            checks++;
            if ({bus.en_cpr, bus.en_spr, bus.en_ram, bus.comp_en} !== e_en) begin
                errors++;
                $display("FAIL enables c=%0d: cpr/spr/ram/comp=%b required %b", c,
                         {bus.en_cpr, bus.en_spr, bus.en_ram, bus.comp_en}, e_en);
            end
            checks++;
            if (bus.cand_x !== PW'(ex) || bus.cand_y !== PW'(ey)) begin
                errors++;
                $display("FAIL cand c=%0d: (%0d,%0d) required (%0d,%0d)", c, bus.cand_x, bus.cand_y, ex, ey);
            end
            if (e_en[1]) begin
                checks++;
                if (bus.addr !== e_addr) begin
                    errors++;
                    $display("FAIL addr c=%0d: %0d required %0d", c, bus.addr, e_addr);
                end
            end
            if (e_en[2]) begin
                checks++;
                if (bus.sel !== e_sel) begin
                    errors++;
                    $display("FAIL sel c=%0d: %0d required %0d", c, bus.sel, e_sel);
                end
            end
            @(posedge clk); #1;
        end

        checks++;
        if (bus.valido !== 1'b1 || bus.readyi !== 1'b0) begin
            errors++;
            $display("FAIL done_latency: valido=%b readyi=%b required 1 0 after %0d cycles", bus.valido, bus.readyi, exp_end);
        end
        checks++;
        if (bus.mv_x !== PW'(exp_mvx) || bus.mv_y !== PW'(exp_mvy) || bus.min_sad !== W'(exp_sad)) begin
            errors++;
            $display("FAIL result: mv=(%0d,%0d) sad=%0d required (%0d,%0d) %0d",
                     bus.mv_x, bus.mv_y, bus.min_sad, exp_mvx, exp_mvy, exp_sad);
        end
        if (release_it) begin
            bus.readyo = 1'b1;
            @(posedge clk); #1;
            bus.readyo = 1'b0;
            checks++;
            if (bus.readyi !== 1'b1 || bus.valido !== 1'b0 || bus.reset_sum !== 1'b1) begin
                errors++;
                $display("FAIL release: readyi=%b valido=%b reset_sum=%b required 1 0 1",
                         bus.readyi, bus.valido, bus.reset_sum);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.start = 1'b1; bus.readyo = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; bus.start = 1'b0; bus.readyo = 1'b0;
        checks++;
        if (bus.readyi !== 1'b1 || bus.reset_sum !== 1'b1 || bus.valido !== 1'b0 ||
            {bus.en_cpr, bus.en_spr, bus.en_ram, bus.comp_en} !== 4'b0000 || bus.addr !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: readyi=%b reset_sum=%b valido=%b en=%b addr=%0d required 1 1 0 0000 0",
                     bus.readyi, bus.reset_sum, bus.valido,
                     {bus.en_cpr, bus.en_spr, bus.en_ram, bus.comp_en}, bus.addr);
        end
        checks++;
        if (bus.min_sad !== 16'hFFFF || bus.mv_x !== '0 || bus.mv_y !== '0 ||
            bus.cand_x !== '0 || bus.cand_y !== '0) begin
            errors++;
            $display("FAIL reset_result: sad=%h mv=(%0d,%0d) cand=(%0d,%0d) required ffff (0,0) (0,0)",
                     bus.min_sad, bus.mv_x, bus.mv_y, bus.cand_x, bus.cand_y);
        end
    endtask

    task automatic test_full_search;
        fill_const(100);
        tab[3][2] = 7;
        run_search(1'b0, 0, 1'b1);
        checks++;
        if (exp_mvx != 3 || exp_mvy != 2 || exp_sad != 7 || bus.mv_x !== 3'd3 || bus.min_sad !== 16'd7) begin
            errors++;
            $display("FAIL full_known: mv=(%0d,%0d) sad=%0d required (3,2) 7", bus.mv_x, bus.mv_y, bus.min_sad);
        end
    endtask

    task automatic test_tie;
        fill_const(50);
        tab[1][1] = 5;
        tab[2][3] = 5;
        run_search(1'b0, 0, 1'b1);
        checks++;
        if (bus.mv_x !== 3'd1 || bus.mv_y !== 3'd1) begin
            errors++;
            $display("FAIL tie_keep_first: mv=(%0d,%0d) required (1,1)", bus.mv_x, bus.mv_y);
        end
    endtask

    task automatic test_early_exit;
        fill_const(100);
        tab[0][3] = 9;
        run_search(1'b1, 10, 1'b1);
        checks++;
        if (bus.mv_x !== 3'd0 || bus.mv_y !== 3'd3 || bus.min_sad !== 16'd9) begin
            errors++;
            $display("FAIL early_known: mv=(%0d,%0d) sad=%0d required (0,3) 9", bus.mv_x, bus.mv_y, bus.min_sad);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            fill_random(1, 200);
            run_search(1'($urandom_range(1, 0)), int'($urandom_range(40, 0)), 1'b1);
        end
    endtask

    task automatic test_done_hold;
        fill_random(1, 300);
        run_search(1'b0, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            bus.start = 1'($urandom_range(1, 0));
            @(posedge clk); #1;
            checks++;
            if (bus.valido !== 1'b1 || bus.readyi !== 1'b0 ||
                {bus.en_cpr, bus.en_spr, bus.en_ram, bus.comp_en} !== 4'b0000 ||
                bus.mv_x !== PW'(exp_mvx) || bus.mv_y !== PW'(exp_mvy) || bus.min_sad !== W'(exp_sad)) begin
                errors++;
                $display("FAIL done_hold i=%0d: valido=%b readyi=%b mv=(%0d,%0d) sad=%0d required 1 0 (%0d,%0d) %0d",
                         i, bus.valido, bus.readyi, bus.mv_x, bus.mv_y, bus.min_sad, exp_mvx, exp_mvy, exp_sad);
            end
        end
        bus.start  = 1'b0;
        bus.readyo = 1'b1;
        @(posedge clk); #1;
        bus.readyo = 1'b0;
        checks++;
        if (bus.readyi !== 1'b1 || bus.valido !== 1'b0) begin
            errors++;
            $display("FAIL done_release: readyi=%b valido=%b required 1 0", bus.readyi, bus.valido);
        end
    endtask

    task automatic test_reset_midscan;
        fill_const(100);
        bus.early_en = 1'b0;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c < 2*M + 5; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (bus.comp_en !== 1'b1 || bus.cand_x !== 3'd0 || bus.cand_y !== 3'd4) begin
            errors++;
            $display("FAIL midscan_pos: comp_en=%b cand=(%0d,%0d) required 1 (0,4)", bus.comp_en, bus.cand_x, bus.cand_y);
        end
        bus.sad_in = 16'd1;
        bus.readyo = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.readyo = 1'b0;
        checks++;
        if (bus.readyi !== 1'b1 || bus.reset_sum !== 1'b1 || bus.comp_en !== 1'b0 || bus.valido !== 1'b0 ||
            bus.min_sad !== 16'hFFFF || bus.mv_x !== '0 || bus.mv_y !== '0) begin
            errors++;
            $display("FAIL midscan_reset: readyi=%b reset_sum=%b comp_en=%b valido=%b sad=%h mv=(%0d,%0d) required 1 1 0 0 ffff (0,0)",
                     bus.readyi, bus.reset_sum, bus.comp_en, bus.valido, bus.min_sad, bus.mv_x, bus.mv_y);
        end
        fill_random(1, 500);
        run_search(1'b0, 0, 1'b1);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.early_en  = 1'b0;
        bus.early_thr = '0;
        bus.sad_in    = '0;
        bus.readyo    = 1'b0;
        test_reset();
        test_full_search();
        test_tie();
        test_early_exit();
        test_random();
        test_done_hold();
        test_reset_midscan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
